// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage that assembles LE words from a byte port; optional I-cache under INST_FETCH_ICACHE_EN.
// Latency: miss 6 cycles LOOKUP->valid with continuous grants (+1 per withheld grant); cache hit 1 cycle.
// Backpressure: stall_in holds the presented word in DONE; jump_in overrides every state.
module inst_fetch #(
  parameter int unsigned ICACHE_LINES = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        jump_in,
  input  logic [31:0] jumpAddr_in,
  output logic        memReq_out,
  output logic [31:0] memAddr_out,
  input  logic        memGrant_in,
  input  logic [7:0]  memData_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        instValid_out
);

  typedef enum logic [1:0] {LOOKUP, FETCH, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [2:0]  issue_idx, issue_nxt;
  logic        pend, pend_nxt;
  logic [1:0]  pend_idx, pend_idx_nxt;
  logic [23:0] byte_buf, byte_buf_nxt;
  logic [31:0] inst_nxt, fill_word, addr_nxt, hit_dat;
  logic        valid_nxt, fill_done, hit;
  logic        unused_jump_lsbs;

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  assign unused_jump_lsbs = ^jumpAddr_in[1:0];
  assign pc_out     = pc;
  assign memReq_out = (state == FETCH) && (issue_idx < 3'd4);
  assign fill_word  = {memData_in, byte_buf};

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    issue_nxt    = issue_idx;
    pend_nxt     = 1'b0;
    pend_idx_nxt = pend_idx;
    byte_buf_nxt = byte_buf;
    inst_nxt     = inst_out;
    valid_nxt    = instValid_out;
    fill_done    = 1'b0;
    if (jump_in) begin
      // Redirect drops any in-flight byte and any word completing this cycle.
      state_nxt = LOOKUP;
      pc_nxt    = {jumpAddr_in[31:2], 2'b00};
      issue_nxt = 3'd0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        LOOKUP: begin
          if (hit) begin
            state_nxt = DONE;
            inst_nxt  = hit_dat;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = FETCH;
            issue_nxt = 3'd0;
          end
        end
        FETCH: begin
          if (issue_idx < 3'd4 && memGrant_in) begin
            issue_nxt    = issue_idx + 3'd1;
            pend_nxt     = 1'b1;
            pend_idx_nxt = issue_idx[1:0];
          end
          if (pend) begin
            case (pend_idx)
              2'd0: byte_buf_nxt[7:0]   = memData_in;
              2'd1: byte_buf_nxt[15:8]  = memData_in;
              2'd2: byte_buf_nxt[23:16] = memData_in;
              default: begin
                state_nxt = DONE;
                inst_nxt  = fill_word;
                valid_nxt = 1'b1;
                fill_done = 1'b1;
              end
            endcase
          end
        end
        DONE: begin
          if (!stall_in) begin
            pc_nxt    = pc + 32'd4;
            state_nxt = LOOKUP;
            valid_nxt = 1'b0;
          end
        end
        default: state_nxt = LOOKUP;
      endcase
    end
    // Address is registered, so it is computed from the values the next cycle will hold.
    addr_nxt = (state_nxt == FETCH && issue_nxt < 3'd4) ? pc_nxt + {29'd0, issue_nxt} : 32'd0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= LOOKUP;
      pc            <= RESET_PC;
      issue_idx     <= 3'd0;
      pend          <= 1'b0;
      pend_idx      <= 2'd0;
      byte_buf      <= 24'd0;
      inst_out      <= 32'd0;
      instValid_out <= 1'b0;
      memAddr_out   <= 32'd0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      issue_idx     <= issue_nxt;
      pend          <= pend_nxt;
      pend_idx      <= pend_idx_nxt;
      byte_buf      <= byte_buf_nxt;
      inst_out      <= inst_nxt;
      instValid_out <= valid_nxt;
      memAddr_out   <= addr_nxt;
    end
  end

`ifdef INST_FETCH_ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] c_vld;
  logic [TAG_W-1:0]        c_tag [ICACHE_LINES];
  logic [31:0]             c_dat [ICACHE_LINES];
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[31:IDX_W+2];
  assign hit     = c_vld[idx] && (c_tag[idx] == tag);
  assign hit_dat = c_dat[idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) c_vld <= '0;
    else if (fill_done) c_vld[idx] <= 1'b1;
  end

  // Tag/data need no reset: the valid bits gate every use.
  always_ff @(posedge clk_in) begin
    if (fill_done) begin
      c_tag[idx] <= tag;
      c_dat[idx] <= fill_word;
    end
  end
`else
  logic unused_fill_done;
  assign unused_fill_done = fill_done;
  assign hit     = 1'b0;
  assign hit_dat = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a transaction-level memory/PC model checked every cycle.
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, stall_in, jump_in, memGrant_in;
  logic [31:0] jumpAddr_in;
  logic [7:0]  memData_in;
  logic        memReq_out, instValid_out;
  logic [31:0] memAddr_out, pc_out, inst_out;

  int checks = 0;
  int errors = 0;

`ifdef INST_FETCH_ICACHE_EN
  localparam int HIT_N   = 1;
  localparam int HIT_REQ = 0;
`else
  localparam int HIT_N   = 6;
  localparam int HIT_REQ = 4;
`endif

  inst_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .jump_in(jump_in),
    .jumpAddr_in(jumpAddr_in), .memReq_out(memReq_out), .memAddr_out(memAddr_out),
    .memGrant_in(memGrant_in), .memData_in(memData_in), .pc_out(pc_out),
    .inst_out(inst_out), .instValid_out(instValid_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Arbiter/memory: grant by default, withhold on a chosen address, return byte next cycle.
  logic [31:0] drop_addr = 32'hFFFF_FFFF;
  int          drop_left = 0;
  initial begin
    logic        prev_g;
    logic [31:0] prev_a;
    prev_g = 1'b0;
    prev_a = 32'd0;
    memGrant_in = 1'b1;
    memData_in  = 8'h00;
    forever begin
      @(posedge clk_in); #2;
      memData_in = prev_g ? mem_byte(prev_a) : 8'hEE;
      memGrant_in = 1'b1;
      if (memReq_out && memAddr_out == drop_addr && drop_left > 0) begin
        memGrant_in = 1'b0;
        drop_left--;
      end
      prev_g = rst_in && memReq_out && memGrant_in;
      prev_a = memAddr_out;
    end
  end

  // Model: expected PC follows consume/jump; requests walk pc+grants; valid words match memory.
  logic [31:0] exp_pc;
  int          grants, req_cycles;
  logic [31:0] granted_q[$];
  initial begin
    logic jumped_prev, consumed_prev;
    exp_pc = 32'd0; grants = 0; req_cycles = 0;
    jumped_prev = 1'b0; consumed_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        exp_pc = 32'd0; grants = 0; jumped_prev = 1'b0; consumed_prev = 1'b0;
      end else begin
        if (jumped_prev) begin
          check("no_req_after_jump", {31'd0, memReq_out}, 32'd0);
          check("no_vld_after_jump", {31'd0, instValid_out}, 32'd0);
        end
        if (consumed_prev) check("no_vld_after_consume", {31'd0, instValid_out}, 32'd0);
        if (instValid_out) begin
          check("model_pc", pc_out, exp_pc);
          check("model_inst", inst_out, mem_word(exp_pc));
          check("no_req_when_vld", {31'd0, memReq_out}, 32'd0);
        end
        if (memReq_out) begin
          check("model_req_addr", memAddr_out, exp_pc + 32'(grants));
          req_cycles++;
          if (memGrant_in) granted_q.push_back(memAddr_out);
        end
        jumped_prev   = jump_in;
        consumed_prev = 1'b0;
        if (jump_in) begin
          exp_pc = {jumpAddr_in[31:2], 2'b00};
          grants = 0;
        end else if (instValid_out && !stall_in) begin
          exp_pc = exp_pc + 32'd4;
          grants = 0;
          consumed_prev = 1'b1;
        end else if (memReq_out && memGrant_in) begin
          grants++;
        end
      end
    end
  end

  task automatic clr_log();
    granted_q.delete();
    req_cycles = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk_in); #2;
      n++;
    end while (!instValid_out && n < 40);
  endtask

  task automatic jump_to(input logic [31:0] a);
    jump_in = 1'b1;
    jumpAddr_in = a;
    @(posedge clk_in); #2;
    jump_in = 1'b0;
    clr_log();
  endtask

  task automatic consume();
    stall_in = 1'b0;
    @(posedge clk_in); #2;
    stall_in = 1'b1;
    clr_log();
  endtask

  task automatic wait_req(input logic [31:0] a, input string nm);
    int k;
    k = 0;
    while (!(memReq_out && memAddr_out == a) && k < 20) begin
      @(posedge clk_in); #2;
      k++;
    end
    check(nm, {31'd0, memReq_out && memAddr_out == a}, 32'd1);
  endtask

  initial begin
    int n;
    rst_in = 1'b0; stall_in = 1'b1; jump_in = 1'b0; jumpAddr_in = 32'd0;
    repeat (3) @(posedge clk_in);
    #2;
    check("rst_vld", {31'd0, instValid_out}, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_req", {31'd0, memReq_out}, 32'd0);
    check("rst_addr", memAddr_out, 32'd0);

    // First miss from reset, continuous grant.
    rst_in = 1'b1;
    clr_log();
    wait_valid(n);
    check("miss_latency", 32'(n), 32'd6);
    check("first_inst", inst_out, 32'h00100513);
    check("first_pc", pc_out, 32'd0);
    check("first_grants", 32'(granted_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < granted_q.size(); i++)
      check("first_addr_seq", granted_q[i], 32'(i));

    // Held by stall.
    clr_log();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #2;
      check("stall_vld", {31'd0, instValid_out}, 32'd1);
      check("stall_inst", inst_out, 32'h00100513);
    end
    check("stall_no_req", 32'(req_cycles), 32'd0);

    // Jump overrides DONE+stall; address 0 refetched (cache hit when built).
    jump_to(32'd0);
    wait_valid(n);
    check("refetch0_latency", 32'(n), 32'(HIT_N));
    check("refetch0_req_cycles", 32'(req_cycles), 32'(HIT_REQ));
    check("refetch0_inst", inst_out, 32'h00100513);

    // Consume, then fetch pc=4 with byte 1 withheld two cycles.
    drop_addr = 32'd5;
    drop_left = 2;
    consume();
    check("consume_pc", pc_out, 32'd4);
    check("consume_vld", {31'd0, instValid_out}, 32'd0);
    wait_valid(n);
    check("drop_latency", 32'(n), 32'd8);
    check("drop_inst", inst_out, 32'h5D5C5F5E);
    check("drop_req_cycles", 32'(req_cycles), 32'd6);

    // Jump during byte 2 of the fetch at 8.
    consume();
    wait_req(32'd10, "reach_byte2");
    jump_to(32'h1003);
    wait_valid(n);
    check("jump_latency", 32'(n), 32'd6);
    check("jump_pc", pc_out, 32'h1000);
    check("jump_inst", inst_out, 32'h49484B4A);
    check("jump_first_addr", granted_q.size() > 0 ? granted_q[0] : 32'hDEAD, 32'h1000);

    // 0x1000 evicted address 0 (same index); miss again, refilling it.
    jump_to(32'd0);
    wait_valid(n);
    check("evict_latency", 32'(n), 32'd6);
    check("evict_inst", inst_out, 32'h00100513);

    // Reset in the middle of a fetch, then cache must be empty.
    jump_to(32'h40);
    @(posedge clk_in); #2;
    @(posedge clk_in); #3;
    rst_in = 1'b0;
    #1;
    check("async_rst_req", {31'd0, memReq_out}, 32'd0);
    check("async_rst_addr", memAddr_out, 32'd0);
    check("async_rst_pc", pc_out, 32'd0);
    check("async_rst_vld", {31'd0, instValid_out}, 32'd0);
    check("async_rst_inst", inst_out, 32'd0);
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    clr_log();
    wait_valid(n);
    check("post_rst_latency", 32'(n), 32'd6);
    check("post_rst_req_cycles", 32'(req_cycles), 32'd4);

    // Jump on the byte-3 capture cycle: word dropped and not cached.
    jump_to(32'h2000);
    wait_req(32'h2003, "reach_byte3");
    @(posedge clk_in); #2;
    jump_to(32'h3000);
    wait_valid(n);
    check("cap_jump_latency", 32'(n), 32'd6);
    check("cap_jump_pc", pc_out, 32'h3000);
    check("cap_jump_inst", inst_out, 32'h69686B6A);
    jump_to(32'h2000);
    wait_valid(n);
    check("not_cached_latency", 32'(n), 32'd6);
    check("not_cached_inst", inst_out, 32'h79787B7A);

    repeat (2) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
